// File: rtl/exu_if.sv
// Bundle of the exu's IDU handshake, data-memory and writeback/retire signals.
// slave is the exu's view; master is the surrounding pipeline/memory view.
interface exu_if;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        alu_src_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        reg_write_i;
  logic [3:0]  alu_op_i;
  logic [1:0]  mem_size_i;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  logic        retire_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  modport slave (
    input  valid_i, rd_i, rs1_i, rs2_i, imm_i, alu_src_i, mem_read_i,
           mem_write_i, reg_write_i, alu_op_i, mem_size_i,
           dmem_ack_i, dmem_rdata_i,
    output ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
           retire_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );

  modport master (
    output valid_i, rd_i, rs1_i, rs2_i, imm_i, alu_src_i, mem_read_i,
           mem_write_i, reg_write_i, alu_op_i, mem_size_i,
           dmem_ack_i, dmem_rdata_i,
    input  ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
           retire_o, wb_we_o, wb_rd_o, wb_data_o, err_o
  );
endinterface

// File: rtl/exu.sv
// Execute/writeback stage: owns the 32x32 register file, runs the ALU,
// issues data-memory accesses and reports each retirement.
//
// state | meaning
// IDLE  | ready for an instruction; operands read from the regfile on accept
// EXEC  | ALU result computed; memory ops checked for alignment / size
// MEM   | data-memory request held until ack or timeout
// WB    | retire pulse; regfile written at the end of this cycle
module exu #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  exu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

  state_t            state;
  logic [XLEN-1:0]   regs [32];
  logic [4:0]        rd_q;
  logic [3:0]        op_q;
  logic              src_q, mr_q, mw_q, rw_q;
  logic [1:0]        sz_q;
  logic [XLEN-1:0]   imm_q, a_q, b_q;
  logic [15:0]       tmr;

  logic [XLEN-1:0]   opb, alu, ld_lane, ld_data, wdata_n;
  logic [4:0]        shamt;
  logic [3:0]        be_n;
  logic              misalign;

  always_comb begin
    opb   = src_q ? imm_q : b_q;
    shamt = opb[4:0];
    alu   = '0;
    unique case (op_q)
      4'd0:    alu = a_q + opb;
      4'd1:    alu = a_q - opb;
      4'd2:    alu = a_q << shamt;
      4'd3:    alu = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(opb))};
      4'd4:    alu = {{(XLEN-1){1'b0}}, (a_q < opb)};
      4'd5:    alu = a_q ^ opb;
      4'd6:    alu = a_q >> shamt;
      4'd7:    alu = XLEN'($signed(a_q) >>> shamt);
      4'd8:    alu = a_q | opb;
      4'd9:    alu = a_q & opb;
      4'd10:   alu = opb;
      default: alu = '0;
    endcase
  end

  // Reserved size is folded into misalign so both abort the same way.
  always_comb begin
    misalign = 1'b0;
    be_n     = 4'hF;
    wdata_n  = b_q;
    unique case (sz_q)
      2'd0: begin
        be_n    = 4'b0001 << alu[1:0];
        wdata_n = {4{b_q[7:0]}};
      end
      2'd1: begin
        misalign = alu[0];
        be_n     = 4'b0011 << alu[1:0];
        wdata_n  = {2{b_q[15:0]}};
      end
      2'd2:    misalign = |alu[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_lane = bus.dmem_rdata_i >> {bus.dmem_addr_o[1:0], 3'b000};
    unique case (sz_q)
      2'd0:    ld_data = {{(XLEN-8){ld_lane[7]}}, ld_lane[7:0]};
      2'd1:    ld_data = {{(XLEN-16){ld_lane[15]}}, ld_lane[15:0]};
      default: ld_data = bus.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rd_q  <= '0;
      op_q  <= '0;
      src_q <= 1'b0;
      mr_q  <= 1'b0;
      mw_q  <= 1'b0;
      rw_q  <= 1'b0;
      sz_q  <= '0;
      imm_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tmr   <= '0;
      bus.ready_o      <= 1'b1;
      bus.dmem_req_o   <= 1'b0;
      bus.dmem_we_o    <= 1'b0;
      bus.dmem_addr_o  <= '0;
      bus.dmem_wdata_o <= '0;
      bus.dmem_be_o    <= '0;
      bus.retire_o     <= 1'b0;
      bus.wb_we_o      <= 1'b0;
      bus.wb_rd_o      <= '0;
      bus.wb_data_o    <= '0;
      bus.err_o        <= 1'b0;
    end else begin
      bus.retire_o  <= 1'b0;
      bus.wb_we_o   <= 1'b0;
      bus.wb_rd_o   <= '0;
      bus.wb_data_o <= '0;
      bus.err_o     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.valid_i) begin
            rd_q  <= bus.rd_i;
            op_q  <= bus.alu_op_i;
            src_q <= bus.alu_src_i;
            mr_q  <= bus.mem_read_i;
            mw_q  <= bus.mem_write_i;
            rw_q  <= bus.reg_write_i;
            sz_q  <= bus.mem_size_i;
            imm_q <= bus.imm_i;
            a_q   <= (bus.rs1_i == 5'd0) ? '0 : regs[bus.rs1_i];
            b_q   <= (bus.rs2_i == 5'd0) ? '0 : regs[bus.rs2_i];
            bus.ready_o <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((mr_q || mw_q) && !misalign) begin
            bus.dmem_req_o   <= 1'b1;
            bus.dmem_we_o    <= mw_q;
            bus.dmem_addr_o  <= alu;
            bus.dmem_wdata_o <= wdata_n;
            bus.dmem_be_o    <= be_n;
            tmr   <= 16'(MEM_TIMEOUT - 1);
            state <= S_MEM;
          end else begin
            bus.retire_o  <= 1'b1;
            bus.wb_rd_o   <= rd_q;
            bus.wb_data_o <= alu;
            bus.err_o     <= mr_q || mw_q;
            bus.wb_we_o   <= rw_q && !mw_q && !mr_q && (rd_q != 5'd0);
            state <= S_WB;
          end
        end
        S_MEM: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (bus.dmem_ack_i || (MEM_TIMEOUT > 0 && tmr == '0)) begin
            bus.dmem_req_o   <= 1'b0;
            bus.dmem_we_o    <= 1'b0;
            bus.dmem_be_o    <= '0;
            bus.dmem_wdata_o <= '0;
            bus.dmem_addr_o  <= '0;
            bus.retire_o     <= 1'b1;
            bus.wb_rd_o      <= rd_q;
            bus.wb_data_o    <= (mr_q && bus.dmem_ack_i) ? ld_data : bus.dmem_addr_o;
            bus.err_o        <= !bus.dmem_ack_i;
            bus.wb_we_o      <= bus.dmem_ack_i && rw_q && !mw_q && (rd_q != 5'd0);
            state <= S_WB;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        S_WB: begin
          if (bus.wb_we_o) regs[bus.wb_rd_o] <= bus.wb_data_o;
          bus.ready_o <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu.sv
// Directed bench for exu: table of ALU instructions with hand-computed results,
// plus hand-written memory, error, timeout and mid-access reset sequences.
module tb_exu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  exu_if bus ();
  exu #(.XLEN(32), .MEM_TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  op;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic src, logic [3:0] op,
                              logic rw, logic exp_we, logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.src = src; v.op = op;
    v.rw = rw; v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic src, input logic [3:0] op,
                       input logic rw, input logic mr, input logic mw, input logic [1:0] sz);
    int n = 0;
    while (bus.ready_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("ready_wait_timeout", 32'(bus.ready_o), 32'd1);
    bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2; bus.imm_i = imm;
    bus.alu_src_i = src; bus.alu_op_i = op; bus.reg_write_i = rw;
    bus.mem_read_i = mr; bus.mem_write_i = mw; bus.mem_size_i = sz;
    bus.valid_i = 1'b1;
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic run_alu(input string name, input vec_t v);
    issue(v.rd, v.rs1, v.rs2, v.imm, v.src, v.op, v.rw, 1'b0, 1'b0, 2'd2);
    chk({name, "_exec_retire"}, 32'(bus.retire_o), 32'd0);
    step();
    chk({name, "_retire"}, 32'(bus.retire_o), 32'd1);
    chk({name, "_we"}, 32'(bus.wb_we_o), 32'(v.exp_we));
    chk({name, "_rd"}, 32'(bus.wb_rd_o), 32'(v.rd));
    chk({name, "_data"}, bus.wb_data_o, v.exp_data);
    chk({name, "_err"}, 32'(bus.err_o), 32'd0);
    step();
    chk({name, "_ready"}, 32'(bus.ready_o), 32'd1);
    chk({name, "_retire_low"}, 32'(bus.retire_o), 32'd0);
  endtask

  // waits: MEM cycles without ack; give_ack: ack on the following cycle.
  // go_mem=0 expects the access to be rejected in EXEC.
  task automatic run_mem(input string name, input logic [4:0] rd, input logic [4:0] rs2,
                         input logic [31:0] addr, input logic mr, input logic mw,
                         input logic rw, input logic [1:0] sz, input bit go_mem,
                         input int waits, input bit give_ack, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic exp_we, input logic [31:0] exp_data, input logic exp_err);
    issue(rd, 5'd0, rs2, addr, 1'b1, 4'd0, rw, mr, mw, sz);
    chk({name, "_exec_req"}, 32'(bus.dmem_req_o), 32'd0);
    step();
    if (go_mem) begin
      chk({name, "_addr"}, bus.dmem_addr_o, addr);
      chk({name, "_be"}, 32'(bus.dmem_be_o), 32'(exp_be));
      chk({name, "_dwe"}, 32'(bus.dmem_we_o), 32'(mw));
      if (mw) chk({name, "_wdata"}, bus.dmem_wdata_o, exp_wdata);
      for (int i = 0; i < waits; i++) begin
        chk({name, "_req_held"}, 32'(bus.dmem_req_o), 32'd1);
        chk({name, "_no_retire"}, 32'(bus.retire_o), 32'd0);
        step();
      end
      if (give_ack) begin
        chk({name, "_req_at_ack"}, 32'(bus.dmem_req_o), 32'd1);
        bus.dmem_ack_i = 1'b1;
        bus.dmem_rdata_i = rdata;
        step();
        bus.dmem_ack_i = 1'b0;
        bus.dmem_rdata_i = '0;
      end
    end
    chk({name, "_req_wb"}, 32'(bus.dmem_req_o), 32'd0);
    chk({name, "_retire"}, 32'(bus.retire_o), 32'd1);
    chk({name, "_err"}, 32'(bus.err_o), 32'(exp_err));
    chk({name, "_we"}, 32'(bus.wb_we_o), 32'(exp_we));
    chk({name, "_rd"}, 32'(bus.wb_rd_o), 32'(rd));
    if (!exp_err) chk({name, "_data"}, bus.wb_data_o, exp_data);
    step();
    chk({name, "_ready"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.imm_i = '0;
    bus.alu_src_i = 1'b0; bus.mem_read_i = 1'b0; bus.mem_write_i = 1'b0;
    bus.reg_write_i = 1'b0; bus.alu_op_i = '0; bus.mem_size_i = '0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;

    //           rd  rs1 rs2  imm           src op    rw we  data
    vt[0]  = mk(1,  0,  0,  32'd5,        1, 4'd0, 1, 1, 32'd5);
    vt[1]  = mk(2,  1,  1,  32'd0,        0, 4'd0, 1, 1, 32'd10);
    vt[2]  = mk(0,  0,  0,  32'd7,        1, 4'd0, 1, 0, 32'd7);
    vt[3]  = mk(4,  0,  2,  32'd0,        0, 4'd0, 1, 1, 32'd10);
    vt[4]  = mk(3,  0,  0,  32'hAB,       1, 4'd0, 1, 1, 32'hAB);
    vt[5]  = mk(5,  0,  0,  32'd1,        1, 4'd1, 1, 1, 32'hFFFF_FFFF);
    vt[6]  = mk(6,  1,  0,  32'h8000_0000, 1, 4'd10, 1, 1, 32'h8000_0000);
    vt[7]  = mk(7,  6,  0,  32'd4,        1, 4'd7, 1, 1, 32'hF800_0000);
    vt[8]  = mk(8,  6,  0,  32'd4,        1, 4'd6, 1, 1, 32'h0800_0000);
    vt[9]  = mk(9,  1,  0,  32'h24,       1, 4'd2, 1, 1, 32'h50);
    vt[10] = mk(10, 5,  1,  32'd0,        0, 4'd3, 1, 1, 32'd1);
    vt[11] = mk(11, 5,  1,  32'd0,        0, 4'd4, 1, 1, 32'd0);
    vt[12] = mk(12, 2,  0,  32'hFF,       1, 4'd5, 1, 1, 32'hF5);
    vt[13] = mk(13, 2,  0,  32'h100,      1, 4'd8, 1, 1, 32'h10A);
    vt[14] = mk(14, 5,  0,  32'h0F0F,     1, 4'd9, 1, 1, 32'h0F0F);
    vt[15] = mk(15, 1,  0,  32'd3,        1, 4'd11, 1, 1, 32'd0);
    vt[16] = mk(16, 5,  0,  32'd1,        1, 4'd0, 1, 1, 32'd0);
    vt[17] = mk(17, 0,  0,  32'd9,        1, 4'd0, 0, 0, 32'd9);
    vt[18] = mk(18, 17, 1,  32'd0,        0, 4'd0, 1, 1, 32'd5);
    vt[19] = mk(19, 5,  5,  32'd0,        0, 4'd15, 1, 1, 32'd0);
    vt[20] = mk(21, 5,  2,  32'd0,        0, 4'd7, 1, 1, 32'hFFFF_FFFF);
    vt[21] = mk(22, 1,  2,  32'd0,        0, 4'd1, 1, 1, 32'hFFFF_FFFB);

    #12;
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_retire", 32'(bus.retire_o), 32'd0);
    chk("rst_wb_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 22; i++) run_alu($sformatf("alu%0d", i), vt[i]);

    //       name     rd  rs2 addr           mr mw rw sz   mem waits ack rdata            be       wdata           we data            err
    run_mem("sb",     0,  3,  32'h1001,      0, 1, 1, 2'd0, 1, 3, 1, 32'h0,           4'b0010, 32'hABABABAB, 0, 32'h1001,      0);
    run_mem("lb",     23, 0,  32'h1001,      1, 0, 1, 2'd0, 1, 1, 1, 32'h0000AB00,    4'b0010, 32'h0,        1, 32'hFFFFFFAB,  0);
    run_mem("lb_pos", 26, 0,  32'h1003,      1, 0, 1, 2'd0, 1, 0, 1, 32'h7F000000,    4'b1000, 32'h0,        1, 32'h7F,        0);
    run_mem("lh",     24, 0,  32'h1002,      1, 0, 1, 2'd1, 1, 0, 1, 32'h80010000,    4'b1100, 32'h0,        1, 32'hFFFF8001,  0);
    run_mem("lw",     25, 0,  32'h1004,      1, 0, 1, 2'd2, 1, 2, 1, 32'h12345678,    4'hF,    32'h0,        1, 32'h12345678,  0);
    run_mem("sh",     0,  3,  32'h1002,      0, 1, 0, 2'd1, 1, 0, 1, 32'h0,           4'b1100, 32'h00AB00AB, 0, 32'h1002,      0);
    run_mem("sw",     0,  2,  32'h1000,      0, 1, 0, 2'd2, 1, 1, 1, 32'h0,           4'hF,    32'h0000000A, 0, 32'h1000,      0);
    run_mem("lw_mis", 27, 0,  32'h1002,      1, 0, 1, 2'd2, 0, 0, 0, 32'h0,           4'h0,    32'h0,        0, 32'h0,         1);
    run_mem("lh_mis", 27, 0,  32'h1001,      1, 0, 1, 2'd1, 0, 0, 0, 32'h0,           4'h0,    32'h0,        0, 32'h0,         1);
    run_mem("sz_rsv", 27, 0,  32'h1000,      1, 0, 1, 2'd3, 0, 0, 0, 32'h0,           4'h0,    32'h0,        0, 32'h0,         1);
    run_mem("tmo",    28, 0,  32'h1000,      1, 0, 1, 2'd2, 1, 4, 0, 32'h0,           4'hF,    32'h0,        0, 32'h0,         1);

    run_alu("rb_lb", mk(29, 23, 0, 32'd0, 0, 4'd0, 1, 1, 32'hFFFFFFAB));
    run_alu("rb_tmo", mk(30, 28, 25, 32'd0, 0, 4'd0, 1, 1, 32'h12345678));
    run_alu("rb_mis", mk(30, 27, 0, 32'd0, 0, 4'd0, 1, 1, 32'd0));

    // Reset in the middle of a memory access.
    issue(5'd31, 5'd0, 5'd0, 32'h1000, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 2'd2);
    step();
    chk("rstmem_req_before", 32'(bus.dmem_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmem_req_async", 32'(bus.dmem_req_o), 32'd0);
    chk("rstmem_ready", 32'(bus.ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    bus.dmem_ack_i = 1'b1;
    bus.dmem_rdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmem_late_ack", 32'(bus.retire_o), 32'd0);
    end
    bus.dmem_ack_i = 1'b0;
    bus.dmem_rdata_i = '0;
    run_alu("rstmem_x1", mk(20, 1, 0, 32'd0, 0, 4'd0, 1, 1, 32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
